// File: rtl/ibex_branch_resolve_pkg.sv
// Shared types and defaults for the static branch prediction resolution path.
package ibex_branch_resolve_pkg;

   localparam int unsigned BP_QUEUE_DEPTH = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        taken;
   } bp_rec_t;

endpackage

// File: rtl/ibex_branch_resolve_if.sv
// Prediction/resolution/redirect bundle between IF/ID, EX and the resolve block.
interface ibex_branch_resolve_if #(
   parameter int unsigned CNT_W = 32
);
   logic             pred_valid_i;
   logic             pred_taken_i;
   logic [31:0]      pred_pc_i;
   logic [31:0]      pred_target_i;
   logic             pred_ready_o;
   logic             res_valid_i;
   logic [31:0]      res_pc_i;
   logic             res_taken_i;
   logic [31:0]      res_target_i;
   logic [31:0]      res_next_pc_i;
   logic             flush_i;
   logic             redirect_o;
   logic [31:0]      redirect_pc_o;
   logic             mispredict_o;
   logic             empty_o;
   logic             tag_err_o;
   logic [CNT_W-1:0] cnt_branch_o;
   logic [CNT_W-1:0] cnt_mispred_o;

   modport master (
      output pred_valid_i, pred_taken_i, pred_pc_i, pred_target_i,
      output res_valid_i, res_pc_i, res_taken_i, res_target_i, res_next_pc_i, flush_i,
      input  pred_ready_o, redirect_o, redirect_pc_o, mispredict_o, empty_o, tag_err_o,
      input  cnt_branch_o, cnt_mispred_o
   );

   modport slave (
      input  pred_valid_i, pred_taken_i, pred_pc_i, pred_target_i,
      input  res_valid_i, res_pc_i, res_taken_i, res_target_i, res_next_pc_i, flush_i,
      output pred_ready_o, redirect_o, redirect_pc_o, mispredict_o, empty_o, tag_err_o,
      output cnt_branch_o, cnt_mispred_o
   );
endinterface

// File: rtl/ibex_branch_resolve_fifo.sv
// Circular prediction-record queue with extra-MSB pointers and synchronous clear.
module ibex_branch_resolve_fifo
   import ibex_branch_resolve_pkg::*;
#(
   parameter int unsigned DEPTH = BP_QUEUE_DEPTH
) (
   input  logic    clk_i,
   input  logic    rst_i,
   input  logic    clr_i,
   input  logic    push_i,
   input  bp_rec_t push_rec_i,
   input  logic    pop_i,
   output bp_rec_t head_o,
   output logic    empty_o,
   output logic    full_o,
   output logic    ready_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   bp_rec_t     r_mem [DEPTH];
   logic [AW:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0] w_wr_nxt, w_rd_nxt;
   logic        r_ready;
   logic        w_push_ok, w_pop_ok, w_full_nxt;

   assign empty_o = (r_wr_ptr == r_rd_ptr);
   assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign ready_o = r_ready;
   assign head_o  = r_mem[r_rd_ptr[AW-1:0]];

   // A pop in the same cycle frees the slot, so a push while full is still accepted
   assign w_pop_ok  = pop_i & ~empty_o;
   assign w_push_ok = push_i & (~full_o | w_pop_ok);

   always_comb begin
      w_wr_nxt = r_wr_ptr + (AW+1)'(w_push_ok);
      w_rd_nxt = r_rd_ptr + (AW+1)'(w_pop_ok);
      if (clr_i) begin
         w_wr_nxt = '0;
         w_rd_nxt = '0;
      end
   end

   assign w_full_nxt = (w_wr_nxt[AW] != w_rd_nxt[AW]) && (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_ready  <= 1'b1;
      end else begin
         r_wr_ptr <= w_wr_nxt;
         r_rd_ptr <= w_rd_nxt;
         r_ready  <= ~w_full_nxt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= push_rec_i;
   end

endmodule

// File: rtl/ibex_branch_resolve.sv
// Checks fetch-side static predictions against EX outcomes; redirects on mispredict.
module ibex_branch_resolve
   import ibex_branch_resolve_pkg::*;
#(
   parameter int unsigned DEPTH = BP_QUEUE_DEPTH,
   parameter int unsigned CNT_W = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   ibex_branch_resolve_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   bp_rec_t          w_head, w_push_rec;
   logic             w_empty, w_full, w_ready;
   logic             w_res, w_res_ok, w_res_empty, w_mis, w_squash;
   logic             w_push, w_push_drop, w_pc_err;
   logic             r_redirect, r_mispredict, r_tag_err;
   logic [31:0]      r_redirect_pc;
   logic [CNT_W-1:0] r_cnt_branch, r_cnt_mispred;

   // Flush overrides both the resolution and the push in the same cycle
   assign w_res       = bus.res_valid_i & ~bus.flush_i;
   assign w_res_ok    = w_res & ~w_empty;
   assign w_res_empty = w_res & w_empty;
   assign w_mis       = (w_head.taken != bus.res_taken_i) |
                        (bus.res_taken_i & (w_head.target != bus.res_target_i));
   assign w_squash    = w_res_ok & w_mis;
   assign w_pc_err    = w_res_ok & (bus.res_pc_i != w_head.pc);
   assign w_push      = bus.pred_valid_i & ~bus.flush_i & ~w_squash;
   assign w_push_drop = w_push & w_full & ~w_res_ok;

   assign w_push_rec = '{pc: bus.pred_pc_i, target: bus.pred_target_i, taken: bus.pred_taken_i};

   ibex_branch_resolve_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (bus.flush_i | w_squash),
      .push_i     (w_push),
      .push_rec_i (w_push_rec),
      .pop_i      (w_res_ok),
      .head_o     (w_head),
      .empty_o    (w_empty),
      .full_o     (w_full),
      .ready_o    (w_ready)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_redirect    <= 1'b0;
         r_mispredict  <= 1'b0;
         r_redirect_pc <= '0;
         r_tag_err     <= 1'b0;
         r_cnt_branch  <= '0;
         r_cnt_mispred <= '0;
      end else begin
         r_redirect   <= w_squash;
         r_mispredict <= w_squash;
         if (w_squash)
            r_redirect_pc <= bus.res_taken_i ? bus.res_target_i : bus.res_next_pc_i;
         if (w_res_empty | w_pc_err | w_push_drop)
            r_tag_err <= 1'b1;
         if (w_res_ok && r_cnt_branch != '1)
            r_cnt_branch <= r_cnt_branch + CNT_ONE;
         if (w_squash && r_cnt_mispred != '1)
            r_cnt_mispred <= r_cnt_mispred + CNT_ONE;
      end
   end

   assign bus.pred_ready_o  = w_ready;
   assign bus.empty_o       = w_empty;
   assign bus.redirect_o    = r_redirect;
   assign bus.mispredict_o  = r_mispredict;
   assign bus.redirect_pc_o = r_redirect_pc;
   assign bus.tag_err_o     = r_tag_err;
   assign bus.cnt_branch_o  = r_cnt_branch;
   assign bus.cnt_mispred_o = r_cnt_mispred;

endmodule

// File: tb/tb_ibex_branch_resolve.sv
// Directed scoreboard bench for ibex_branch_resolve (DEPTH=4, CNT_W=4).
module tb_ibex_branch_resolve;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   ibex_branch_resolve_if #(.CNT_W(4)) bus();

   ibex_branch_resolve #(
      .DEPTH (4),
      .CNT_W (4)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Every redirect pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (bus.redirect_o || bus.mispredict_o) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_redirect: pc 0x%0h, none expected", bus.redirect_pc_o);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (bus.redirect_pc_o !== e || bus.redirect_o !== 1'b1 || bus.mispredict_o !== 1'b1) begin
               n_fail++;
               $display("FAIL redirect: pc 0x%0h redir %0b mis %0b expected pc 0x%0h redir 1 mis 1",
                        bus.redirect_pc_o, bus.redirect_o, bus.mispredict_o, e);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.pred_valid_i = 1'b0; bus.pred_taken_i = 1'b0;
      bus.pred_pc_i = '0;      bus.pred_target_i = '0;
      bus.res_valid_i = 1'b0;  bus.res_pc_i = '0;  bus.res_taken_i = 1'b0;
      bus.res_target_i = '0;   bus.res_next_pc_i = '0;
      bus.flush_i = 1'b0;
   endtask

   task automatic set_push(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
      bus.pred_valid_i = 1'b1; bus.pred_pc_i = pc;
      bus.pred_target_i = tgt; bus.pred_taken_i = tk;
   endtask

   task automatic set_res(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic [31:0] nxt);
      bus.res_valid_i = 1'b1; bus.res_pc_i = pc; bus.res_taken_i = tk;
      bus.res_target_i = tgt; bus.res_next_pc_i = nxt;
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
      set_push(pc, tgt, tk);
      cyc();
      idle();
   endtask

   task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic [31:0] nxt, input logic exp_redir, input logic [31:0] exp_pc);
      set_res(pc, tk, tgt, nxt);
      if (exp_redir) exp_q.push_back(exp_pc);
      cyc();
      idle();
   endtask

   task automatic sb_drain(input string name);
      cyc(); cyc();
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      idle();
      cyc(); cyc();
      rst = 1'b0;
      check("rst_empty", bus.empty_o, 1);
      check("rst_ready", bus.pred_ready_o, 1);
      check("rst_redirect", bus.redirect_o, 0);
      check("rst_redirect_pc", bus.redirect_pc_o, 0);
      check("rst_tag_err", bus.tag_err_o, 0);
      check("rst_cnt_branch", bus.cnt_branch_o, 0);

      // correct prediction
      push(32'h100, 32'hF0, 1'b1);
      check("t1_not_empty", bus.empty_o, 0);
      resolve(32'h100, 1'b1, 32'hF0, 32'h104, 1'b0, 0);
      check("t1_cnt_branch", bus.cnt_branch_o, 1);
      check("t1_cnt_mispred", bus.cnt_mispred_o, 0);
      check("t1_empty", bus.empty_o, 1);
      sb_drain("t1_sb");

      // direction mispredict, squashes younger entry and a same-cycle push
      push(32'h200, 32'h0, 1'b0);
      push(32'h204, 32'h180, 1'b1);
      set_push(32'h208, 32'h0, 1'b0);
      resolve(32'h200, 1'b1, 32'h240, 32'h204, 1'b1, 32'h240);
      check("t2_empty", bus.empty_o, 1);
      check("t2_cnt_mispred", bus.cnt_mispred_o, 1);
      check("t2_cnt_branch", bus.cnt_branch_o, 2);
      check("t2_tag_err", bus.tag_err_o, 0);
      sb_drain("t2_sb");

      // target mispredict
      push(32'h300, 32'h2C0, 1'b1);
      resolve(32'h300, 1'b1, 32'h2C4, 32'h304, 1'b1, 32'h2C4);
      check("t3_cnt_mispred", bus.cnt_mispred_o, 2);
      sb_drain("t3_sb");

      // full queue, push+pop while full, overflow push, drain
      for (int i = 0; i < 4; i++) push(32'h400 + 32'(4*i), 32'h0, 1'b0);
      check("t4_ready_full", bus.pred_ready_o, 0);
      set_push(32'h410, 32'h0, 1'b0);
      resolve(32'h400, 1'b0, 32'h0, 32'h404, 1'b0, 0);
      check("t4_pp_ready", bus.pred_ready_o, 0);
      check("t4_pp_tag_err", bus.tag_err_o, 0);
      check("t4_pp_branch", bus.cnt_branch_o, 4);
      push(32'h500, 32'h0, 1'b0);
      check("t4_ovf_tag_err", bus.tag_err_o, 1);
      for (int i = 1; i < 5; i++) resolve(32'h400 + 32'(4*i), 1'b0, 32'h0, 32'h404 + 32'(4*i), 1'b0, 0);
      check("t4_drain_empty", bus.empty_o, 1);
      check("t4_drain_ready", bus.pred_ready_o, 1);
      check("t4_drain_branch", bus.cnt_branch_o, 8);
      check("t4_drain_mispred", bus.cnt_mispred_o, 2);
      sb_drain("t4_sb");

      // reset alongside a mispredicting resolution suppresses the redirect
      push(32'h700, 32'h0, 1'b0);
      set_res(32'h700, 1'b1, 32'h740, 32'h704);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      idle();
      check("mrst_tag_err", bus.tag_err_o, 0);
      check("mrst_cnt_branch", bus.cnt_branch_o, 0);
      check("mrst_cnt_mispred", bus.cnt_mispred_o, 0);
      check("mrst_empty", bus.empty_o, 1);
      check("mrst_redirect", bus.redirect_o, 0);
      sb_drain("mrst_sb");

      // flush beats a mispredicting resolution
      push(32'h600, 32'h0, 1'b0);
      push(32'h604, 32'h0, 1'b0);
      bus.flush_i = 1'b1;
      resolve(32'h600, 1'b1, 32'h640, 32'h604, 1'b0, 0);
      check("t5_empty", bus.empty_o, 1);
      check("t5_redirect", bus.redirect_o, 0);
      check("t5_cnt_branch", bus.cnt_branch_o, 0);
      check("t5_cnt_mispred", bus.cnt_mispred_o, 0);
      check("t5_tag_err", bus.tag_err_o, 0);
      sb_drain("t5_sb");

      // resolve on empty queue, then saturation
      resolve(32'h800, 1'b0, 32'h0, 32'h804, 1'b0, 0);
      check("t6_empty_tag_err", bus.tag_err_o, 1);
      check("t6_empty_cnt_branch", bus.cnt_branch_o, 0);
      for (int i = 0; i < 17; i++) begin
         push(32'h900 + 32'(8*i), 32'h0, 1'b0);
         resolve(32'h900 + 32'(8*i), 1'b1, 32'hA00 + 32'(4*i), 32'h904 + 32'(8*i),
                 1'b1, 32'hA00 + 32'(4*i));
         if (i == 14) check("t6_cnt_at_15", bus.cnt_mispred_o, 15);
      end
      check("t6_sat_branch", bus.cnt_branch_o, 15);
      check("t6_sat_mispred", bus.cnt_mispred_o, 15);
      sb_drain("t6_sb");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
